// File: rtl/wb_mem_loader_pkg.sv
// Shared types for the Wishbone memory loader: FSM state encoding and bus constants.
package wb_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WR,
    ST_RD,
    ST_FIN
  } state_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/wb_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and holds it until the
// consumer takes it; no further bytes are accepted while a word is pending.
module wb_byte_packer (
  input  logic        clk_top,
  input  logic        rst_top,
  input  logic        i_enable,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_word_valid,
  output logic [31:0] o_word,
  input  logic        i_word_taken
);

  logic [1:0]  cnt_q;
  logic [1:0]  cnt_d;
  logic [31:0] word_q;
  logic        valid_q;
  logic        accept;

  assign o_byte_ready = i_enable && !valid_q;
  assign accept       = i_byte_valid && o_byte_ready;
  assign cnt_d        = cnt_q + 2'd1;
  assign o_word_valid = valid_q;
  assign o_word       = word_q;

  // Byte k of the word lands in bits [8k+7:8k]; the counter wraps after byte 3.
  always_ff @(posedge clk_top or posedge rst_top) begin
    if (rst_top) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (i_word_taken) valid_q <= 1'b0;
      if (accept) begin
        word_q[{cnt_q, 3'b000} +: 8] <= i_byte;
        cnt_q <= cnt_d;
        if (cnt_q == 2'd3) valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_mem_loader.sv
// Wishbone master that turns a byte stream into 32-bit RAM writes, optionally
// reading each word back to verify it, and reports done/error status.
module wb_mem_loader
  import wb_mem_loader_pkg::*;
#(
  parameter int AW      = 8,
  parameter bit VERIFY  = 1'b1,
  parameter int TIMEOUT = 15
) (
  input  logic          clk_top,
  input  logic          rst_top,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_adr,
  input  logic [AW:0]   i_num_words,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  output logic          o_byte_ready,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic          i_wb_ack,
  input  logic [31:0]   i_wb_rdt,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [AW-1:0] o_err_adr
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e        state_q;
  logic [AW-1:0] adr_q;
  logic [AW-1:0] adr_d;
  logic [AW:0]   rem_q;
  logic [AW:0]   rem_d;
  logic [AW-1:0] err_adr_q;
  logic [31:0]   dat_q;
  logic [7:0]    tmo_q;
  logic          stb_q;
  logic          we_q;
  logic          done_q;
  logic          error_q;
  logic          word_valid;
  logic          word_taken;
  logic [31:0]   word;

  assign word_taken = (state_q == ST_COLLECT) && word_valid;
  assign adr_d      = adr_q + AW'(1);
  assign rem_d      = rem_q - (AW+1)'(1);

  wb_byte_packer u_packer (
    .clk_top      (clk_top),
    .rst_top      (rst_top),
    .i_enable     (state_q == ST_COLLECT),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_word_valid (word_valid),
    .o_word       (word),
    .i_word_taken (word_taken)
  );

  // RD is entered with stb low so every bus cycle starts from a fresh stb rise;
  // the timeout counter restarts on each rise and ack always wins over expiry.
  always_ff @(posedge clk_top or posedge rst_top) begin
    if (rst_top) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      rem_q     <= '0;
      err_adr_q <= '0;
      dat_q     <= '0;
      tmo_q     <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            adr_q     <= i_base_adr;
            rem_q     <= i_num_words;
            error_q   <= 1'b0;
            err_adr_q <= '0;
            if (i_num_words == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (word_valid) begin
            dat_q   <= word;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            tmo_q   <= '0;
            state_q <= ST_WR;
          end
        end
        ST_WR, ST_RD: begin
          if (!stb_q) begin
            stb_q <= 1'b1;
            we_q  <= 1'b0;
            tmo_q <= '0;
          end else if (i_wb_ack) begin
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            if (state_q == ST_WR && VERIFY) begin
              state_q <= ST_RD;
            end else if (state_q == ST_RD && i_wb_rdt != dat_q) begin
              error_q   <= 1'b1;
              err_adr_q <= adr_q;
              state_q   <= ST_IDLE;
            end else begin
              adr_q <= adr_d;
              rem_q <= rem_d;
              if (rem_d == '0) begin
                state_q <= ST_FIN;
                done_q  <= 1'b1;
              end else begin
                state_q <= ST_COLLECT;
              end
            end
          end else if (tmo_q == TMO_LAST) begin
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            error_q   <= 1'b1;
            err_adr_q <= adr_q;
            state_q   <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        ST_FIN: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_sel  = stb_q ? SEL_ALL : 4'h0;
  assign o_wb_we   = we_q;
  assign o_wb_stb  = stb_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_done    = done_q;
  assign o_error   = error_q;
  assign o_err_adr = err_adr_q;

endmodule

// File: tb/tb_wb_mem_loader.sv
// Bench for wb_mem_loader: a behavioural single-cycle-ack RAM slave and a randomized
// byte source, checked against a little-endian packing model of the expected RAM.
module tb_wb_mem_loader;

  localparam int AW      = 8;
  localparam int TIMEOUT = 15;
  localparam int DEPTH   = 1 << AW;

  logic          clk_top = 1'b0;
  logic          rst_top;
  logic          i_start;
  logic [AW-1:0] i_base_adr;
  logic [AW:0]   i_num_words;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          o_byte_ready;
  logic [AW-1:0] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_stb;
  logic          i_wb_ack;
  logic [31:0]   i_wb_rdt;
  logic          o_busy;
  logic          o_done;
  logic          o_error;
  logic [AW-1:0] o_err_adr;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ram    [DEPTH];
  logic [31:0] expMem [DEPTH];
  bit          slaveNoAck = 1'b0;
  bit          corruptEn  = 1'b0;
  logic [AW-1:0] corruptAdr = '0;

  int doneCount   = 0;
  int stbRises    = 0;
  int wrAcks      = 0;
  int rdAcks      = 0;
  int readyCycles = 0;
  logic          prevStb = 1'b0;
  logic [AW-1:0] prevAdr = '0;
  logic [31:0]   prevDat = '0;
  logic          prevWe  = 1'b0;

  always #5 clk_top = ~clk_top;

  wb_mem_loader #(.AW(AW), .VERIFY(1'b1), .TIMEOUT(TIMEOUT)) dut (
    .clk_top      (clk_top),
    .rst_top      (rst_top),
    .i_start      (i_start),
    .i_base_adr   (i_base_adr),
    .i_num_words  (i_num_words),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_wb_adr     (o_wb_adr),
    .o_wb_dat     (o_wb_dat),
    .o_wb_sel     (o_wb_sel),
    .o_wb_we      (o_wb_we),
    .o_wb_stb     (o_wb_stb),
    .i_wb_ack     (i_wb_ack),
    .i_wb_rdt     (i_wb_rdt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_err_adr    (o_err_adr)
  );

  // RAM stand-in: registered one-cycle ack, refilled with a known pattern on reset.
  always @(posedge clk_top or posedge rst_top) begin
    if (rst_top) begin
      i_wb_ack <= 1'b0;
      i_wb_rdt <= '0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'hDEAD_0000 + 32'(i);
    end else begin
      i_wb_ack <= 1'b0;
      if (o_wb_stb && !i_wb_ack && !slaveNoAck) begin
        i_wb_ack <= 1'b1;
        if (o_wb_we) ram[o_wb_adr] <= o_wb_dat;
        else i_wb_rdt <= ram[o_wb_adr] ^ ((corruptEn && o_wb_adr == corruptAdr) ? 32'd1 : 32'd0);
      end
    end
  end

  // Bus monitor: event counters plus per-cycle protocol checks on sel and held fields.
  always @(negedge clk_top) begin
    if (!rst_top) begin
      if (o_done) doneCount++;
      if (o_byte_ready) readyCycles++;
      if (o_wb_stb && !prevStb) stbRises++;
      if (o_wb_stb && i_wb_ack) begin
        if (o_wb_we) wrAcks++;
        else rdAcks++;
      end
      if (o_wb_stb) begin
        vectors++;
        if (o_wb_sel !== 4'hF) begin
          miscompares++;
          $display("[TB] FAIL busSel: got %h expected f", o_wb_sel);
        end
      end
      if (o_wb_stb && prevStb) begin
        vectors++;
        if ({o_wb_adr, o_wb_dat, o_wb_we} !== {prevAdr, prevDat, prevWe}) begin
          miscompares++;
          $display("[TB] FAIL busHold: got adr %h dat %h we %b expected adr %h dat %h we %b",
                   o_wb_adr, o_wb_dat, o_wb_we, prevAdr, prevDat, prevWe);
        end
      end
    end
    prevStb = o_wb_stb;
    prevAdr = o_wb_adr;
    prevDat = o_wb_dat;
    prevWe  = o_wb_we;
  end

  function automatic logic [31:0] packLe(input logic [7:0] b0, input logic [7:0] b1,
                                         input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) + 32'(b1) * 32'd256 + 32'(b2) * 32'd65536 + 32'(b3) * 32'd16777216;
  endfunction

  task automatic step();
    @(posedge clk_top);
    #1;
  endtask

  task automatic pulseStart(input logic [AW-1:0] base, input logic [AW:0] num);
    i_base_adr  = base;
    i_num_words = num;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$], input int gapPct, output bit ok);
    ok = 1'b1;
    foreach (bytes[i]) begin
      bit accepted;
      int budget;
      for (int g = 0; g < 4 && ($urandom_range(0, 99) < gapPct); g++) begin
        i_byte_valid = 1'b0;
        step();
      end
      i_byte_valid = 1'b1;
      i_byte       = bytes[i];
      accepted     = 1'b0;
      budget       = 0;
      while (!accepted) begin
        accepted = o_byte_ready;
        step();
        budget++;
        if (!accepted && budget > 200) begin
          ok = 1'b0;
          i_byte_valid = 1'b0;
          return;
        end
      end
    end
    i_byte_valid = 1'b0;
  endtask

  task automatic waitEnd(input int budget, output bit finished, output bit errored);
    finished = 1'b0;
    errored  = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (o_done) begin finished = 1'b1; return; end
      if (o_error) begin errored = 1'b1; return; end
      step();
    end
  endtask

  task automatic makeBytes(input int n, output logic [7:0] bytes[$]);
    bytes = {};
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask

  task automatic modelWords(input logic [AW-1:0] base, input logic [7:0] bytes[$], input int n);
    for (int w = 0; w < n; w++)
      expMem[(int'(base) + w) % DEPTH] = packLe(bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]);
  endtask

  task automatic doLoad(input logic [AW-1:0] base, input int n, input int gapPct,
                        input logic [7:0] bytes[$], output bit ok, output bit fin, output bit err);
    modelWords(base, bytes, n);
    pulseStart(base, (AW+1)'(n));
    applyStimulus(bytes, gapPct, ok);
    waitEnd(400, fin, err);
  endtask

  task automatic test_reset();
    vectors++;
    if (o_wb_stb !== 1'b0) begin
      miscompares++; $display("[TB] FAIL resetStb: got %b expected 0", o_wb_stb);
    end
    vectors++;
    if ({o_busy, o_done, o_error, o_byte_ready, o_wb_we, o_wb_sel} !== 9'd0) begin
      miscompares++;
      $display("[TB] FAIL resetFlags: got %b expected 0", {o_busy, o_done, o_error, o_byte_ready, o_wb_we, o_wb_sel});
    end
    vectors++;
    if ({o_wb_adr, o_wb_dat, o_err_adr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL resetBus: got adr %h dat %h erradr %h expected 0", o_wb_adr, o_wb_dat, o_err_adr);
    end
    rst_top = 1'b0;
    repeat (2) step();
    vectors++;
    if ({o_busy, o_byte_ready} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL idleAfterReset: got %b expected 00", {o_busy, o_byte_ready});
    end
  endtask

  task automatic test_single_word();
    logic [7:0] bytes[$];
    bit ok, fin, err;
    int w0, r0, d0;
    w0 = wrAcks; r0 = rdAcks; d0 = doneCount;
    bytes = {8'h5A, 8'hA5, 8'h3C, 8'hC3};
    doLoad(8'h0A, 1, 0, bytes, ok, fin, err);
    vectors++;
    if (!(ok && fin && !err)) begin
      miscompares++; $display("[TB] FAIL singleEnd: got ok %b done %b err %b expected 1 1 0", ok, fin, err);
    end
    vectors++;
    if (ram[8'h0A] !== 32'hC33CA55A) begin
      miscompares++; $display("[TB] FAIL singleWord: got %h expected c33ca55a", ram[8'h0A]);
    end
    step();
    vectors++;
    if ({o_done, o_busy, o_error} !== 3'b000) begin
      miscompares++; $display("[TB] FAIL singleIdle: got %b expected 000", {o_done, o_busy, o_error});
    end
    vectors++;
    if ((wrAcks - w0) != 1 || (rdAcks - r0) != 1 || (doneCount - d0) != 1) begin
      miscompares++;
      $display("[TB] FAIL singleTraffic: got wr %0d rd %0d done %0d expected 1 1 1", wrAcks - w0, rdAcks - r0, doneCount - d0);
    end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] bytes[$];
    bit ok, fin, err;
    int w0;
    int adrs[6] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    w0 = wrAcks;
    makeBytes(16, bytes);
    doLoad(8'hFE, 4, 30, bytes, ok, fin, err);
    vectors++;
    if (!(ok && fin && !err)) begin
      miscompares++; $display("[TB] FAIL wrapEnd: got ok %b done %b err %b expected 1 1 0", ok, fin, err);
    end
    foreach (adrs[i]) begin
      vectors++;
      if (ram[adrs[i]] !== expMem[adrs[i]]) begin
        miscompares++; $display("[TB] FAIL wrapWord %h: got %h expected %h", adrs[i], ram[adrs[i]], expMem[adrs[i]]);
      end
    end
    vectors++;
    if ((wrAcks - w0) != 4) begin
      miscompares++; $display("[TB] FAIL wrapWrites: got %0d expected 4", wrAcks - w0);
    end
    step();
  endtask

  task automatic test_random_loads();
    for (int it = 0; it < 6; it++) begin
      logic [7:0] bytes[$];
      bit ok, fin, err;
      logic [AW-1:0] base;
      int n, bad, firstBad;
      base = AW'($urandom);
      n    = $urandom_range(1, 6);
      makeBytes(4 * n, bytes);
      doLoad(base, n, $urandom_range(0, 50), bytes, ok, fin, err);
      vectors++;
      if (!(ok && fin && !err)) begin
        miscompares++; $display("[TB] FAIL randEnd%0d: got ok %b done %b err %b expected 1 1 0", it, ok, fin, err);
      end
      bad = 0; firstBad = 0;
      for (int a = 0; a < DEPTH; a++)
        if (ram[a] !== expMem[a]) begin
          if (bad == 0) firstBad = a;
          bad++;
        end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("[TB] FAIL randRam%0d: got %0d bad words (first %0d = %h) expected %h", it, bad, firstBad, ram[firstBad], expMem[firstBad]);
      end
      step();
    end
  endtask

  task automatic test_full_range();
    logic [7:0] bytes[$];
    bit ok, fin, err;
    int w0, bad;
    w0 = wrAcks;
    makeBytes(4 * DEPTH, bytes);
    doLoad(AW'($urandom), DEPTH, 0, bytes, ok, fin, err);
    vectors++;
    if (!(ok && fin && !err)) begin
      miscompares++; $display("[TB] FAIL fullEnd: got ok %b done %b err %b expected 1 1 0", ok, fin, err);
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== expMem[a]) bad++;
    vectors++;
    if (bad != 0 || (wrAcks - w0) != DEPTH) begin
      miscompares++; $display("[TB] FAIL fullRam: got %0d bad, %0d writes expected 0 bad, %0d writes", bad, wrAcks - w0, DEPTH);
    end
    step();
  endtask

  task automatic test_zero_count();
    int d0, s0, r0;
    d0 = doneCount; s0 = stbRises; r0 = readyCycles;
    pulseStart(AW'($urandom), '0);
    vectors++;
    if ({o_done, o_busy} !== 2'b11) begin
      miscompares++; $display("[TB] FAIL zeroDone: got done/busy %b expected 11", {o_done, o_busy});
    end
    step();
    vectors++;
    if ({o_done, o_busy} !== 2'b00) begin
      miscompares++; $display("[TB] FAIL zeroAfter: got done/busy %b expected 00", {o_done, o_busy});
    end
    repeat (3) step();
    vectors++;
    if (stbRises != s0 || readyCycles != r0 || (doneCount - d0) != 1) begin
      miscompares++;
      $display("[TB] FAIL zeroQuiet: got stb %0d ready %0d done %0d expected 0 0 1", stbRises - s0, readyCycles - r0, doneCount - d0);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] bytes[$];
    logic [AW-1:0] base;
    bit ok, found;
    int d0, high;
    slaveNoAck = 1'b1;
    base = AW'($urandom);
    d0 = doneCount;
    makeBytes(4, bytes);
    pulseStart(base, 9'd2);
    applyStimulus(bytes, 0, ok);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_wb_stb) begin found = 1'b1; break; end
      step();
    end
    vectors++;
    if (!(ok && found)) begin
      miscompares++; $display("[TB] FAIL tmoStart: got ok %b stb %b expected 1 1", ok, found);
    end
    high = 0;
    while (o_wb_stb && high < 300) begin
      high++;
      step();
    end
    vectors++;
    if (high != TIMEOUT) begin
      miscompares++; $display("[TB] FAIL tmoCycles: got %0d expected %0d", high, TIMEOUT);
    end
    vectors++;
    if ({o_error, o_busy} !== 2'b10 || o_err_adr !== base) begin
      miscompares++;
      $display("[TB] FAIL tmoStatus: got err/busy %b adr %h expected 10 adr %h", {o_error, o_busy}, o_err_adr, base);
    end
    repeat (3) step();
    vectors++;
    if (doneCount != d0 || o_error !== 1'b1 || ram[base] !== expMem[base]) begin
      miscompares++;
      $display("[TB] FAIL tmoAfter: got done %0d err %b ram %h expected 0 1 %h", doneCount - d0, o_error, ram[base], expMem[base]);
    end
    slaveNoAck = 1'b0;
  endtask

  task automatic test_mismatch();
    logic [7:0] bytes[$];
    logic [AW-1:0] base;
    bit ok, fin, err;
    int d0;
    base = AW'($urandom);
    corruptAdr = base + AW'(1);
    corruptEn  = 1'b1;
    d0 = doneCount;
    makeBytes(8, bytes);
    modelWords(base, bytes, 2);
    pulseStart(base, 9'd3);
    applyStimulus(bytes, 10, ok);
    waitEnd(100, fin, err);
    vectors++;
    if (!(ok && err && !fin)) begin
      miscompares++; $display("[TB] FAIL mmEnd: got ok %b err %b done %b expected 1 1 0", ok, err, fin);
    end
    vectors++;
    if (o_err_adr !== corruptAdr) begin
      miscompares++; $display("[TB] FAIL mmAdr: got %h expected %h", o_err_adr, corruptAdr);
    end
    vectors++;
    if (ram[base] !== expMem[base] || ram[corruptAdr] !== expMem[corruptAdr]) begin
      miscompares++;
      $display("[TB] FAIL mmRam: got %h %h expected %h %h", ram[base], ram[corruptAdr], expMem[base], expMem[corruptAdr]);
    end
    step();
    vectors++;
    if (o_busy !== 1'b0 || doneCount != d0) begin
      miscompares++; $display("[TB] FAIL mmIdle: got busy %b done %0d expected 0 0", o_busy, doneCount - d0);
    end
    corruptEn = 1'b0;
    pulseStart(AW'($urandom), '0);
    vectors++;
    if (o_error !== 1'b0) begin
      miscompares++; $display("[TB] FAIL errClear: got %b expected 0", o_error);
    end
    repeat (2) step();
  endtask

  task automatic test_reset_in_wr();
    logic [7:0] bytes[$];
    bit ok, fin, err, found;
    int bad;
    slaveNoAck = 1'b1;
    makeBytes(4, bytes);
    pulseStart(AW'($urandom), 9'd1);
    applyStimulus(bytes, 0, ok);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_wb_stb && o_wb_we) begin found = 1'b1; break; end
      step();
    end
    #2;
    rst_top = 1'b1;
    #1;
    vectors++;
    if (!found || o_wb_stb !== 1'b0) begin
      miscompares++; $display("[TB] FAIL rstStb: got in-WR %b stb %b expected 1 0", found, o_wb_stb);
    end
    vectors++;
    if ({o_busy, o_done, o_error, o_byte_ready, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat, o_err_adr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL rstOutputs: got busy %b we %b sel %h adr %h dat %h expected all 0", o_busy, o_wb_we, o_wb_sel, o_wb_adr, o_wb_dat);
    end
    for (int i = 0; i < DEPTH; i++) expMem[i] = 32'hDEAD_0000 + 32'(i);
    step();
    rst_top    = 1'b0;
    slaveNoAck = 1'b0;
    step();
    makeBytes(12, bytes);
    doLoad(AW'($urandom), 3, 20, bytes, ok, fin, err);
    vectors++;
    if (!(ok && fin && !err)) begin
      miscompares++; $display("[TB] FAIL rstReload: got ok %b done %b err %b expected 1 1 0", ok, fin, err);
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== expMem[a]) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("[TB] FAIL rstReloadRam: got %0d bad words expected 0", bad);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[$];
    logic [AW-1:0] base;
    logic [AW-1:0] other;
    bit ok, fin, err;
    int d0, w0;
    base  = AW'($urandom);
    other = base + AW'(100);
    d0 = doneCount; w0 = wrAcks;
    makeBytes(8, bytes);
    modelWords(base, bytes, 2);
    pulseStart(base, 9'd2);
    fork
      applyStimulus(bytes, 20, ok);
      begin
        repeat (3) step();
        pulseStart(other, 9'd1);
      end
    join
    waitEnd(200, fin, err);
    vectors++;
    if (!(ok && fin && !err)) begin
      miscompares++; $display("[TB] FAIL busyStartEnd: got ok %b done %b err %b expected 1 1 0", ok, fin, err);
    end
    vectors++;
    if (ram[base] !== expMem[base] || ram[base + AW'(1)] !== expMem[base + AW'(1)] || ram[other] !== expMem[other]) begin
      miscompares++;
      $display("[TB] FAIL busyStartRam: got %h %h %h expected %h %h %h", ram[base], ram[base + AW'(1)], ram[other],
               expMem[base], expMem[base + AW'(1)], expMem[other]);
    end
    repeat (4) step();
    vectors++;
    if ((doneCount - d0) != 1 || (wrAcks - w0) != 2 || o_busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busyStartCount: got done %0d wr %0d busy %b expected 1 2 0", doneCount - d0, wrAcks - w0, o_busy);
    end
  endtask

  initial begin
    i_start      = 1'b0;
    i_base_adr   = '0;
    i_num_words  = '0;
    i_byte_valid = 1'b0;
    i_byte       = '0;
    rst_top      = 1'b0;
    for (int i = 0; i < DEPTH; i++) expMem[i] = 32'hDEAD_0000 + 32'(i);
    #1;
    rst_top = 1'b1;
    repeat (3) @(posedge clk_top);
    #1;
    test_reset();
    test_single_word();
    test_burst_wrap();
    test_random_loads();
    test_zero_count();
    test_timeout();
    test_mismatch();
    test_reset_in_wr();
    test_back_to_back();
    test_full_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
